// File: rtl/rc5_pkg.sv
// Shared types and constants for the rc5 core and its host-side controller.
package rc5_pkg;

    localparam int unsigned RC5_CORE_LAT = 11;
    localparam int unsigned RC5_BLK_W    = 64;
    localparam int unsigned RC5_KEY_W    = 128;

    localparam logic RC5_ENC = 1'b1;
    localparam logic RC5_DEC = 1'b0;

    typedef enum logic [2:0] {
        ST_NOKEY,
        ST_KEYLOAD,
        ST_KEYWAIT,
        ST_READY,
        ST_BUSY,
        ST_HOLD
    } rc5_state_e;

endpackage

// File: rtl/rc5_chain_reg.sv
// CBC chain register with IV load and mode-dependent pre/post XOR.
// Built only when RC5_CBC_CTRL_CBC_EN is defined.
`ifdef RC5_CBC_CTRL_CBC_EN
module rc5_chain_reg
    import rc5_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [RC5_BLK_W-1:0] i_iv,
    input  logic                 i_iv_load,
    input  logic                 i_mode,
    input  logic [RC5_BLK_W-1:0] i_blk,
    input  logic                 i_accept,
    input  logic [RC5_BLK_W-1:0] i_core_dout,
    input  logic                 i_capture,
    input  logic                 i_cap_mode,
    output logic [RC5_BLK_W-1:0] o_din_c,
    output logic [RC5_BLK_W-1:0] o_result_c
);

    logic [RC5_BLK_W-1:0] chain_q, chain_d;
    logic [RC5_BLK_W-1:0] post_q, post_d;
    logic [RC5_BLK_W-1:0] chain_eff_c;

    // An IV load in the accept cycle takes effect for that same block.
    assign chain_eff_c = i_iv_load ? i_iv : chain_q;
    assign o_din_c     = (i_mode == RC5_ENC) ? (i_blk ^ chain_eff_c) : i_blk;
    assign o_result_c  = i_core_dout ^ post_q;

    // post_q keeps the decrypt XOR operand since chain_q moves on at accept.
    always_comb begin
        chain_d = chain_eff_c;
        post_d  = post_q;
        if (i_accept) begin
            post_d = (i_mode == RC5_ENC) ? '0 : chain_eff_c;
            if (i_mode == RC5_DEC) begin
                chain_d = i_blk;
            end
        end else if (i_capture && (i_cap_mode == RC5_ENC)) begin
            chain_d = i_core_dout;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chain_q <= '0;
            post_q  <= '0;
        end else begin
            chain_q <= chain_d;
            post_q  <= post_d;
        end
    end

endmodule
`endif

// File: rtl/rc5_cbc_ctrl.sv
// Host-side initiator for the rc5 core: key handshake, block stream, CBC chaining.
// RC5_CBC_CTRL_CBC_EN enables CBC; otherwise the controller runs pure ECB.
module rc5_cbc_ctrl
    import rc5_pkg::*;
#(
    parameter int unsigned CORE_LAT = RC5_CORE_LAT
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_mode,
    input  logic [RC5_KEY_W-1:0] i_key,
    input  logic                 i_key_load,
    output logic                 o_key_ready,
    input  logic [RC5_BLK_W-1:0] i_iv,
    input  logic                 i_iv_load,
    input  logic [RC5_BLK_W-1:0] i_blk,
    input  logic                 i_blk_valid,
    output logic                 o_blk_ready,
    output logic [RC5_BLK_W-1:0] o_blk,
    output logic                 o_blk_valid,
    input  logic                 i_blk_ready,
    output logic                 o_busy,
    output logic                 o_core_flag,
    output logic [RC5_KEY_W-1:0] o_core_key,
    output logic                 o_core_key_en,
    input  logic                 i_core_key_ok,
    output logic [RC5_BLK_W-1:0] o_core_din,
    output logic                 o_core_din_en,
    input  logic [RC5_BLK_W-1:0] i_core_dout,
    input  logic                 i_core_dout_en
);

    localparam int unsigned LAT_W = $clog2(CORE_LAT + 1);

    rc5_state_e           state_q, state_d;
    logic [RC5_KEY_W-1:0] key_q, key_d;
    logic                 key_en_q, key_en_d;
    logic                 flag_q, flag_d;
    logic [RC5_BLK_W-1:0] din_q, din_d;
    logic                 din_en_q, din_en_d;
    logic [RC5_BLK_W-1:0] blk_q, blk_d;
    logic                 blk_valid_q, blk_valid_d;
    logic                 blk_ready_q, blk_ready_d;
    logic                 key_ready_q, key_ready_d;
    logic                 busy_q, busy_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic                 accept_c, capture_c;
    logic [RC5_BLK_W-1:0] core_din_c, result_c;

`ifdef RC5_CBC_CTRL_CBC_EN
    logic iv_load_c;
    assign iv_load_c = i_iv_load && (state_q inside {ST_NOKEY, ST_KEYWAIT, ST_READY});

    rc5_chain_reg u_chain (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_iv        (i_iv),
        .i_iv_load   (iv_load_c),
        .i_mode      (i_mode),
        .i_blk       (i_blk),
        .i_accept    (accept_c),
        .i_core_dout (i_core_dout),
        .i_capture   (capture_c),
        .i_cap_mode  (flag_q),
        .o_din_c     (core_din_c),
        .o_result_c  (result_c)
    );
`else
    logic unused_ecb;
    assign unused_ecb = ^{i_iv, i_iv_load, accept_c, capture_c};
    assign core_din_c = i_blk;
    assign result_c   = i_core_dout;
`endif

    // Key load overrides everything; lat_q screens out early stale dout_en.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_en_d    = 1'b0;
        flag_d      = flag_q;
        din_d       = din_q;
        din_en_d    = 1'b0;
        blk_d       = blk_q;
        blk_valid_d = blk_valid_q;
        lat_d       = lat_q;
        accept_c    = 1'b0;
        capture_c   = 1'b0;
        if (i_key_load) begin
            state_d     = ST_KEYLOAD;
            key_d       = i_key;
            key_en_d    = 1'b1;
            blk_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_KEYLOAD: state_d = ST_KEYWAIT;
                ST_KEYWAIT: if (i_core_key_ok) state_d = ST_READY;
                ST_READY: begin
                    if (i_blk_valid) begin
                        accept_c = 1'b1;
                        flag_d   = i_mode;
                        din_d    = core_din_c;
                        din_en_d = 1'b1;
                        lat_d    = '0;
                        state_d  = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (lat_q != LAT_W'(CORE_LAT)) lat_d = lat_q + LAT_W'(1);
                    if (i_core_dout_en && (lat_q >= LAT_W'(CORE_LAT))) begin
                        capture_c   = 1'b1;
                        blk_d       = result_c;
                        blk_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (i_blk_ready) begin
                        blk_valid_d = 1'b0;
                        state_d     = ST_READY;
                    end
                end
                default: state_d = ST_NOKEY;
            endcase
        end
        key_ready_d = state_d inside {ST_READY, ST_BUSY, ST_HOLD};
        busy_d      = state_d inside {ST_KEYLOAD, ST_KEYWAIT, ST_BUSY, ST_HOLD};
        blk_ready_d = (state_d == ST_READY);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_NOKEY;
            key_q       <= '0;
            key_en_q    <= 1'b0;
            flag_q      <= 1'b0;
            din_q       <= '0;
            din_en_q    <= 1'b0;
            blk_q       <= '0;
            blk_valid_q <= 1'b0;
            blk_ready_q <= 1'b0;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_en_q    <= key_en_d;
            flag_q      <= flag_d;
            din_q       <= din_d;
            din_en_q    <= din_en_d;
            blk_q       <= blk_d;
            blk_valid_q <= blk_valid_d;
            blk_ready_q <= blk_ready_d;
            key_ready_q <= key_ready_d;
            busy_q      <= busy_d;
            lat_q       <= lat_d;
        end
    end

    // A same-cycle key load must block acceptance, hence the live gate.
    assign o_blk_ready   = blk_ready_q & ~i_key_load;
    assign o_key_ready   = key_ready_q;
    assign o_blk         = blk_q;
    assign o_blk_valid   = blk_valid_q;
    assign o_busy        = busy_q;
    assign o_core_flag   = flag_q;
    assign o_core_key    = key_q;
    assign o_core_key_en = key_en_q;
    assign o_core_din    = din_q;
    assign o_core_din_en = din_en_q;

endmodule

// File: tb/tb_rc5_cbc_ctrl.sv
// Bench for rc5_cbc_ctrl with a behavioural RC5-32/12/16 core and a result scoreboard.
`timescale 1ns/1ps
module tb_rc5_cbc_ctrl;
    import rc5_pkg::*;

    localparam int unsigned KEY_DLY      = 20;
    localparam int unsigned ACC_TO_VALID = RC5_CORE_LAT + 1;
`ifdef RC5_CBC_CTRL_CBC_EN
    localparam bit CBC = 1'b1;
`else
    localparam bit CBC = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          i_mode = 1'b0, i_key_load = 1'b0, i_iv_load = 1'b0;
    logic          i_blk_valid = 1'b0, i_blk_ready = 1'b0;
    logic [127:0]  i_key = '0;
    logic [63:0]   i_iv = '0, i_blk = '0;
    logic          o_key_ready, o_blk_ready, o_blk_valid, o_busy;
    logic          o_core_flag, o_core_key_en, o_core_din_en;
    logic [63:0]   o_blk, o_core_din;
    logic [127:0]  o_core_key;
    logic          core_key_ok, core_dout_en;
    logic [63:0]   core_dout;

    rc5_cbc_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(i_mode), .i_key(i_key),
        .i_key_load(i_key_load), .o_key_ready(o_key_ready), .i_iv(i_iv),
        .i_iv_load(i_iv_load), .i_blk(i_blk), .i_blk_valid(i_blk_valid),
        .o_blk_ready(o_blk_ready), .o_blk(o_blk), .o_blk_valid(o_blk_valid),
        .i_blk_ready(i_blk_ready), .o_busy(o_busy), .o_core_flag(o_core_flag),
        .o_core_key(o_core_key), .o_core_key_en(o_core_key_en),
        .i_core_key_ok(core_key_ok), .o_core_din(o_core_din),
        .o_core_din_en(o_core_din_en), .i_core_dout(core_dout),
        .i_core_dout_en(core_dout_en)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0, n_mis = 0, n_acc = 0;
    int unsigned cyc = 0, din_cnt = 0, key_en_cnt = 0;
    logic [63:0] sb[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_core_din_en) din_cnt <= din_cnt + 1;
        if (o_core_key_en) key_en_cnt <= key_en_cnt + 1;
    end

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [31:0] s);
        int unsigned r;
        r = {27'd0, s[4:0]};
        return (r == 0) ? x : ((x << r) | (x >> (32 - r)));
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [31:0] s);
        int unsigned r;
        r = {27'd0, s[4:0]};
        return (r == 0) ? x : ((x >> r) | (x << (32 - r)));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // RC5-32/12/16, bytes in host order, little-endian words inside.
    function automatic logic [63:0] rc5_ref(input logic [127:0] key, input logic [63:0] blk,
                                            input logic enc);
        logic [31:0] s [0:25];
        logic [31:0] l [0:3];
        logic [31:0] a, b;
        int ii, jj;
        for (int k = 0; k < 4; k++) l[k] = bswap(key[127 - 32*k -: 32]);
        s[0] = 32'hB7E15163;
        for (int k = 1; k < 26; k++) s[k] = s[k-1] + 32'h9E3779B9;
        a = '0; b = '0; ii = 0; jj = 0;
        for (int k = 0; k < 78; k++) begin
            a = rotl(s[ii] + a + b, 32'd3);
            s[ii] = a;
            b = rotl(l[jj] + a + b, a + b);
            l[jj] = b;
            ii = (ii + 1) % 26;
            jj = (jj + 1) % 4;
        end
        a = bswap(blk[63:32]);
        b = bswap(blk[31:0]);
        if (enc) begin
            a = a + s[0];
            b = b + s[1];
            for (int r = 1; r <= 12; r++) begin
                a = rotl(a ^ b, b) + s[2*r];
                b = rotl(b ^ a, a) + s[2*r+1];
            end
        end else begin
            for (int r = 12; r >= 1; r--) begin
                b = rotr(b - s[2*r+1], a) ^ a;
                a = rotr(a - s[2*r], b) ^ b;
            end
            b = b - s[1];
            a = a - s[0];
        end
        return {bswap(a), bswap(b)};
    endfunction

    // Core model: key_ok after KEY_DLY edges, dout_en CORE_LAT cycles after din_en.
    int unsigned key_cnt;
    logic [10:0] pv;
    logic [63:0] pd [0:10];
    assign core_dout_en = pv[10];
    assign core_dout    = pd[10];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_key_ok <= 1'b0;
            key_cnt     <= 0;
            pv          <= '0;
            for (int k = 0; k < 11; k++) pd[k] <= '0;
        end else begin
            if (o_core_key_en) begin
                core_key_ok <= 1'b0;
                key_cnt     <= KEY_DLY;
            end else if (key_cnt != 0) begin
                key_cnt <= key_cnt - 1;
                if (key_cnt == 1) core_key_ok <= 1'b1;
            end
            pv    <= {pv[9:0], o_core_din_en};
            pd[0] <= o_core_din_en ? rc5_ref(o_core_key, o_core_din, o_core_flag) : 64'h0;
            for (int k = 1; k < 11; k++) pd[k] <= pd[k-1];
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_ne(input string nm, input logic [63:0] act, input logic [63:0] avoid);
        n_cmp++;
        if (act === avoid) begin
            n_mis++;
            $display("FAIL %s: got %0h must differ from %0h", nm, act, avoid);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_key_ready(input string nm);
        int n = 0;
        while (!o_key_ready && n < 100) begin tick(); n++; end
        chk(nm, o_key_ready, 1'b1);
    endtask

    task automatic load_key(input logic [127:0] k);
        i_key = k; i_key_load = 1'b1;
        tick();
        i_key_load = 1'b0;
        chk("key_ready_fall", o_key_ready, 1'b0);
        chk("core_key", o_core_key, k);
        wait_key_ready("key_ready_rise");
    endtask

    task automatic load_iv(input logic [63:0] iv);
        i_iv = iv; i_iv_load = 1'b1;
        tick();
        i_iv_load = 1'b0;
    endtask

    task automatic wait_blk_ready(output bit ok);
        int n = 0;
        while (!o_blk_ready && n < 100) begin tick(); n++; end
        ok = o_blk_ready;
        if (!ok) chk("blk_ready_timeout", o_blk_ready, 1'b1);
    endtask

    // Push expectation at accept, pop when the DUT presents its result.
    task automatic send(input string nm, input logic mode, input logic [63:0] blk,
                        input logic iv_ld, input logic [63:0] iv, input logic [63:0] exp,
                        input int hold, output logic [63:0] got);
        bit ok;
        int n = 0;
        int unsigned acc, dc;
        bit stable;
        logic [63:0] e;
        got = '0;
        wait_blk_ready(ok);
        if (!ok) return;
        i_mode = mode; i_blk = blk; i_blk_valid = 1'b1; i_iv_load = iv_ld; i_iv = iv;
        tick();
        acc = cyc;
        i_blk_valid = 1'b0; i_iv_load = 1'b0;
        sb.push_back(exp);
        n_acc++;
        chk("din_en_pulse", o_core_din_en, 1'b1);
        while (!o_blk_valid && n < 40) begin tick(); n++; end
        chk("blk_valid_rise", o_blk_valid, 1'b1);
        if (!o_blk_valid) begin void'(sb.pop_front()); return; end
        chk("latency", cyc - acc, ACC_TO_VALID);
        got = o_blk;
        if (hold > 0) begin
            stable = 1'b1;
            dc = din_cnt;
            i_blk = ~blk; i_blk_valid = 1'b1;
            repeat (hold) begin
                tick();
                if (o_blk !== got || !o_blk_valid || o_blk_ready) stable = 1'b0;
            end
            i_blk_valid = 1'b0;
            tick();
            chk("bp_stable", stable, 1'b1);
            chk("bp_no_din", din_cnt - dc, 0);
        end
        e = sb.pop_front();
        chk(nm, o_blk, e);
        i_blk_ready = 1'b1;
        tick();
        i_blk_ready = 1'b0;
        chk("valid_clear", o_blk_valid, 1'b0);
    endtask

    typedef struct {
        logic        mode;
        logic [63:0] blk;
        logic        iv_ld;
        logic [63:0] exp;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [6];
        logic [63:0] pt [3];
        logic [63:0] ct [3];
        logic [63:0] ch, got, ct1, exp;
        logic [127:0] k1, k2;
        logic [63:0] iv1, iv2;
        int unsigned k0, dc;
        bit ok, seen;
        int n;

        k1  = 128'h0123456789ABCDEF_FEDCBA9876543210;
        k2  = 128'h00112233445566778899AABBCCDDEEFF;
        iv1 = 64'h0123456789ABCDEF;
        iv2 = 64'h55AA55AA0F0F0F0F;
        pt[0] = 64'h0000000000000000;
        pt[1] = 64'h0000000000000000;
        pt[2] = 64'hDEADBEEFCAFEF00D;

        ch = iv1;
        for (int i = 0; i < 3; i++) begin
            ct[i] = rc5_ref(k1, CBC ? (pt[i] ^ ch) : pt[i], RC5_ENC);
            ch = ct[i];
            tbl[i] = '{RC5_ENC, pt[i], 1'b0, ct[i]};
        end
        for (int i = 0; i < 3; i++) tbl[3+i] = '{RC5_DEC, ct[i], (i == 0), pt[i]};

        // Reset: everything idle, blk_ready low even with a pending block.
        i_blk_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(); tick();
        chk("rst_blk_ready", o_blk_ready, 1'b0);
        chk("rst_key_ready", o_key_ready, 1'b0);
        chk("rst_blk_valid", o_blk_valid, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_core_key_en", o_core_key_en, 1'b0);
        chk("rst_core_din_en", o_core_din_en, 1'b0);
        chk("rst_core_flag", o_core_flag, 1'b0);
        chk("rst_blk", o_blk, 64'h0);
        chk("rst_core_din", o_core_din, 64'h0);
        chk("rst_core_key", o_core_key, 128'h0);
        i_blk_valid = 1'b0;

        // Zero key and IV, encrypt zero block: known RC5 vector.
        k0 = key_en_cnt;
        load_key('0);
        chk("key_en_once", key_en_cnt - k0, 1);
        send("zero_vector", RC5_ENC, 64'h0, 1'b0, 64'h0, 64'h21A5DBEE154B8F6D, 0, got);

        // CBC round trip; decrypt IV reload coincides with the first accept.
        load_key(k1);
        load_iv(iv1);
        ct1 = '0;
        for (int i = 0; i < 6; i++) begin
            send($sformatf("vec%0d", i), tbl[i].mode, tbl[i].blk, tbl[i].iv_ld, iv1,
                 tbl[i].exp, 0, got);
            if (i == 1) ct1 = got;
        end
`ifdef RC5_CBC_CTRL_CBC_EN
        chk_ne("cbc_vs_ecb", ct1, rc5_ref(k1, pt[1], RC5_ENC));
`endif
        ch = ct[2];

        // Backpressure for 20 cycles with a competing block offered.
        exp = rc5_ref(k1, CBC ? (64'h1122334455667788 ^ ch) : 64'h1122334455667788, RC5_ENC);
        send("bp_result", RC5_ENC, 64'h1122334455667788, 1'b0, 64'h0, exp, 20, got);

        // Key reload while BUSY: in-flight result must never appear.
        wait_blk_ready(ok);
        i_mode = RC5_ENC; i_blk = 64'h0F1E2D3C4B5A6978; i_blk_valid = 1'b1;
        tick();
        i_blk_valid = 1'b0;
        n_acc++;
        repeat (4) tick();
        i_key = k2; i_key_load = 1'b1;
        tick();
        i_key_load = 1'b0;
        chk("reload_key_ready_fall", o_key_ready, 1'b0);
        chk("reload_busy", o_busy, 1'b1);
        seen = 1'b0;
        n = 0;
        while (!o_key_ready && n < 100) begin
            tick();
            n++;
            if (o_blk_valid) seen = 1'b1;
        end
        chk("reload_key_ready_rise", o_key_ready, 1'b1);
        chk("reload_stale_hidden", seen, 1'b0);
        exp = rc5_ref(k2, CBC ? (64'hA5A5A5A5A5A5A5A5 ^ iv2) : 64'hA5A5A5A5A5A5A5A5, RC5_ENC);
        send("new_key_result", RC5_ENC, 64'hA5A5A5A5A5A5A5A5, 1'b1, iv2, exp, 0, got);

        // Key load and block valid together in READY: key wins.
        wait_blk_ready(ok);
        i_key = k2; i_key_load = 1'b1; i_blk_valid = 1'b1; i_blk = 64'h1;
        #1;
        chk("kl_blk_ready_low", o_blk_ready, 1'b0);
        tick();
        i_key_load = 1'b0; i_blk_valid = 1'b0;
        dc = din_cnt;
        chk("kl_no_din_en", o_core_din_en, 1'b0);
        chk("kl_key_ready_fall", o_key_ready, 1'b0);
        wait_key_ready("kl_key_ready_rise");
        chk("kl_no_din_total", din_cnt - dc, 0);
        chk("kl_no_result", o_blk_valid, 1'b0);
        chk("din_en_total", din_cnt, n_acc);

        // Asynchronous reset in the middle of a block.
        wait_blk_ready(ok);
        i_mode = RC5_ENC; i_blk = 64'h77; i_blk_valid = 1'b1;
        tick();
        i_blk_valid = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", o_busy, 1'b0);
        chk("arst_key_ready", o_key_ready, 1'b0);
        chk("arst_core_din", o_core_din, 64'h0);
        chk("arst_core_key", o_core_key, 128'h0);
        chk("arst_core_flag", o_core_flag, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_blk_ready", o_blk_ready, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/rc5_cbc_ctrl.md
# rc5_cbc_ctrl

Host-side initiator for the `rc5` core. It owns the core's key and data handshakes: it issues the key-expansion start, waits for `key_ok`, then feeds 64-bit blocks one at a time and collects results. It adds CBC chaining around the ECB core and presents a valid/ready stream interface to the surrounding design. It sits between the system bus adapter and the `rc5` instance, and is the only driver of the core's inputs.

## Interface
Parameters:
- `CORE_LAT`, 11: cycles from core `din_en` to core `dout_en`; fixed by the core.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_mode`  in  1  1 = encrypt, 0 = decrypt; sampled on block accept
- `i_key`  in  128  cipher key; sampled when `i_key_load` is high
- `i_key_load`  in  1  one-cycle pulse; starts key expansion
- `o_key_ready`  out  1  key expansion complete; blocks may be accepted
- `i_iv`  in  64  CBC initial vector
- `i_iv_load`  in  1  loads `i_iv` into the chain register
- `i_blk`, `i_blk_valid`, `o_blk_ready`  in/in/out  64/1/1  input block stream
- `o_blk`, `o_blk_valid`, `i_blk_ready`  out/out/in  64/1/1  result stream
- `o_busy`  out  1  high in KEYLOAD, KEYWAIT, BUSY and HOLD
- `o_core_flag`, `o_core_key`, `o_core_key_en`  out  1/128/1  to core
- `i_core_key_ok`  in  1  from core
- `o_core_din`, `o_core_din_en`  out  64/1  to core
- `i_core_dout`, `i_core_dout_en`  in  64/1  from core

## Operation
- State machine: NOKEY, KEYLOAD, KEYWAIT, READY, BUSY, HOLD.
  - NOKEY: reset state; `o_blk_ready` = 0.
  - `i_key_load` in any state moves to KEYLOAD. It registers `i_key`, discards any in-flight block, clears `o_blk_valid`, and drives `o_core_key_en` high for exactly one cycle.
  - KEYLOAD → KEYWAIT unconditionally. KEYWAIT → READY on `i_core_key_ok`.
  - READY: `o_blk_ready` = 1. On `i_blk_valid & o_blk_ready`, latch `i_mode` into `o_core_flag`, load `o_core_din`, pulse `o_core_din_en` for one cycle, then go to BUSY.
  - BUSY: on `i_core_dout_en`, capture the result into `o_blk`, set `o_blk_valid`, go to HOLD.
  - HOLD: on `i_blk_ready`, clear `o_blk_valid` and go to READY.
- Encrypt: core input = `i_blk ^ chain`; result = core output; chain ← core output.
- Decrypt: core input = `i_blk`; result = core output `^ chain`; chain ← `i_blk` (latched at accept).
- All XORs are plain 64-bit bitwise operations in host byte order. The core's internal byte swap commutes with XOR.
- `i_iv_load`:
  - Honoured in NOKEY, KEYWAIT and READY; ignored in BUSY and HOLD.
  - If it coincides with a block accept in READY, the IV is loaded first and used for that block.
- Simultaneous `i_key_load` and `i_blk_valid`: the key load wins. `o_blk_ready` is forced low that cycle, and the block is not accepted.
- `o_core_flag` is held constant from accept until the next accept, so the core never sees a flag change mid-block.
- `o_core_key` is held between loads.

## Timing
- Reset values: `o_key_ready`, `o_blk_ready`, `o_blk_valid`, `o_busy`, `o_core_key_en`, `o_core_din_en`, `o_core_flag` are 0. `o_blk`, `o_core_din`, `o_core_key` and chain are all-zero.
- Accept at edge t:
  - `o_core_din_en` is high in cycle t+1.
  - `i_core_dout_en` arrives in cycle t+1+`CORE_LAT`.
  - `o_blk_valid` rises in cycle t+2+`CORE_LAT` (t+13).
- Throughput: one block per 14 cycles at best (accept, 12 cycles in flight, one HOLD cycle with `i_blk_ready` = 1).
- `o_blk`/`o_blk_valid` stay stable while `i_blk_ready` = 0.
- `o_key_ready` is registered: it is high only in READY, BUSY and HOLD, and falls the cycle after `i_key_load`.
- Reset asserted mid-operation returns to NOKEY immediately, and all outputs take their reset values asynchronously.
- If `i_core_dout_en` arrives outside BUSY, it is ignored.

## Configuration
- `RC5_CBC_CTRL_CBC_EN` defined: CBC chaining as above; `i_iv`/`i_iv_load` are functional.
- Not defined:
  - Pure ECB: core input = `i_blk`, result = core output.
  - The chain register is not built, and `i_iv`/`i_iv_load` are ignored.
  - Handshake timing is identical.

## Structure
- Shared package `rc5_pkg` holds:
  - the state enum;
  - `RC5_CORE_LAT` = 11;
  - `RC5_BLK_W` = 64 and `RC5_KEY_W` = 128;
  - the mode constants (`RC5_ENC` = 1, `RC5_DEC` = 0).
- One sub-module is natural: `rc5_chain_reg`. It holds the chain register, IV load, and the pre-/post-XOR muxing by mode. It is compiled only under `RC5_CBC_CTRL_CBC_EN`.

## Test plan
- Reset: release `i_rst_n` → all outputs zero, state NOKEY, `o_blk_ready` = 0 even with `i_blk_valid` = 1.
- Key and IV zero, encrypt block 0x0 → `o_core_key_en` pulses once, `o_key_ready` rises after core `key_ok`, and `o_blk` = 0x21A5DBEE154B8F6D exactly 13 cycles after accept.
- CBC round-trip: IV = 0x0123456789ABCDEF, encrypt 3 blocks, reload the same IV, decrypt the 3 ciphertexts → the original plaintexts are returned, and the second ciphertext differs from the ECB result for the same plaintext.
- Backpressure: hold `i_blk_ready` = 0 for 20 cycles → `o_blk` stable, `o_blk_ready` = 0, no second `o_core_din_en`.
- Key reload while in BUSY → the in-flight result is never presented, `o_key_ready` falls next cycle, and a fresh block after the new `key_ok` encrypts under the new key.
- `i_key_load` and `i_blk_valid` in the same cycle in READY → block not accepted, no `o_core_din_en`.
